// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants, class encoding and packed result layout
package fp32_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [30:0] FP32_INF     = 31'h7F800000;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a 24-bit significand with guard/sticky
module fp_round_rne
    import fp32_pkg::*;
(
    input  logic [23:0] sig,
    input  logic        guard,
    input  logic        sticky,
    input  logic [7:0]  exp,
    output logic [23:0] sig_out,
    output logic [8:0]  exp_out,
    output logic        carry,
    output logic        inexact
);

    logic        inc;
    logic [24:0] sum;

    always_comb begin
        inc     = guard & (sticky | sig[0]);
        sum     = {1'b0, sig} + {24'd0, inc};
        carry   = sum[24];
        inexact = guard | sticky;
        if (carry) begin
            sig_out = sum[24:1];
            exp_out = {1'b0, exp} + 9'd1;
        end else begin
            sig_out = sum[23:0];
            // a denormal that rounds up into the hidden bit becomes the smallest normal
            exp_out = (exp == 8'd0 && sum[23]) ? 9'd1 : {1'b0, exp};
        end
    end

endmodule

// File: rtl/fp32_mul_pack.sv
// rtl/fp32_mul_pack.sv - FP32 multiplier back end: normalize, denormalize, round, pack
module fp32_mul_pack
    import fp32_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_prod,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    localparam int EW = EXP_W + 2;

    logic s1_valid, s2_valid, s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    logic signed [EW-1:0] e_in, e_a, e_f, lz_s, sh_full;
    logic [5:0]           lz, sh;
    logic [46:0]          p_a, p_d;
    logic                 st_a, lost;
    logic [7:0]           a_exp;
    fp_class_t            a_class;

    always_comb begin
        e_in = {{2{in_exp[EXP_W-1]}}, in_exp};
        lz   = 6'd0;
        for (int i = 0; i < 47; i++) begin
            if (in_prod[i]) lz = 6'(46 - i);
        end
        lz_s = EW'(lz);

        p_a  = in_prod[46:0];
        st_a = 1'b0;
        e_a  = e_in;
        if (in_prod[47]) begin
            p_a  = in_prod[47:1];
            st_a = in_prod[0];
            e_a  = e_in + EW'(1);
        end else if (!in_prod[46] && in_prod != 48'd0) begin
            p_a = in_prod[46:0] << lz;
            e_a = e_in - lz_s;
        end

        // beyond 26 places every significand bit lands below guard, so clamp the shifter
        sh_full = EW'(1) - e_a;
        sh      = 6'd0;
        p_d     = p_a;
        lost    = 1'b0;
        e_f     = e_a;
        if (e_a <= EW'(0)) begin
            sh   = (sh_full > EW'(26)) ? 6'd26 : sh_full[5:0];
            p_d  = p_a >> sh;
            lost = |(p_a & ~({47{1'b1}} << sh));
            e_f  = EW'(0);
        end

        a_exp = (e_f >= EW'(255)) ? FP32_EXP_MAX : e_f[7:0];

        if (in_nan)                              a_class = NAN;
        else if (in_inf)                         a_class = INF;
        else if (in_zero || in_prod == 48'd0)    a_class = ZERO;
        else                                     a_class = NORM;
    end

    logic [23:0] s1_sig;
    logic        s1_guard, s1_sticky, s1_sign;
    logic [7:0]  s1_exp;
    fp_class_t   s1_class;

    logic [23:0] r_sig;
    logic [8:0]  r_exp;
    logic        r_carry, r_inexact;

    fp_round_rne u_round (
        .sig     (s1_sig),
        .guard   (s1_guard),
        .sticky  (s1_sticky),
        .exp     (s1_exp),
        .sig_out (r_sig),
        .exp_out (r_exp),
        .carry   (r_carry),
        .inexact (r_inexact)
    );

    fp32_t pk;
    logic  n_ovf, n_unf, n_inx;

    always_comb begin
        pk    = '0;
        n_ovf = 1'b0;
        n_unf = 1'b0;
        n_inx = 1'b0;
        case (s1_class)
            NAN:  pk = FP32_QNAN;
            INF:  pk = {s1_sign, FP32_INF};
            ZERO: pk = {s1_sign, 31'd0};
            default: begin
                if (r_exp >= {1'b0, FP32_EXP_MAX}) begin
                    pk    = {s1_sign, FP32_INF};
                    n_ovf = 1'b1;
                    n_inx = 1'b1;
                end else begin
                    pk.sign = s1_sign;
                    pk.exp  = r_sig[23] ? r_exp[7:0] : 8'd0;
                    pk.man  = r_carry ? 23'd0 : r_sig[22:0];
                    n_inx   = r_inexact;
                    n_unf   = (s1_exp == 8'd0) && r_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            out_result    <= 32'd0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_sig    <= p_d[46:23];
                s1_guard  <= p_d[22];
                s1_sticky <= (|p_d[21:0]) | lost | st_a;
                s1_exp    <= a_exp;
                s1_sign   <= in_sign;
                s1_class  <= a_class;
            end
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                out_result    <= pk;
                out_overflow  <= n_ovf;
                out_underflow <= n_unf;
                out_inexact   <= n_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_pack.sv
// tb/tb_fp32_mul_pack.sv - directed-vector bench for fp32_mul_pack
module tb_fp32_mul_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [47:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign, in_zero, in_inf, in_nan;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_mul_pack #(.EXP_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_prod       (in_prod),
        .in_exp        (in_exp),
        .in_sign       (in_sign),
        .in_zero       (in_zero),
        .in_inf        (in_inf),
        .in_nan        (in_nan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    // cls = {nan, inf, zero}
    task automatic set_in(input logic [47:0] p, input logic [9:0] e, input logic s, input logic [2:0] cls);
        in_prod = p;
        in_exp  = e;
        in_sign = s;
        in_nan  = cls[2];
        in_inf  = cls[1];
        in_zero = cls[0];
    endtask

    // Sends one vector with out_ready=1 and returns what came out; x on timeout.
    task automatic apply(input logic [47:0] p, input logic [9:0] e, input logic s, input logic [2:0] cls,
                         output logic [31:0] res, output logic [2:0] fl, output int lat);
        int w;
        res = 'x;
        fl  = 'x;
        lat = -1;
        out_ready = 1'b1;
        @(negedge clk);
        set_in(p, e, s, cls);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid) begin
                res = out_result;
                fl  = {out_overflow, out_underflow, out_inexact};
                lat = k;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_in(48'd0, 10'd0, 1'b0, 3'b000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_result !== 32'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=00000000", out_result); end
        checks++;
        if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {out_overflow, out_underflow, out_inexact});
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_normal;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        apply(48'h4000_0000_0000, 10'd127, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h3F800000) begin failures++; $display("FAIL one_x_one got=%h exp=3f800000", r); end
        checks++;
        if (f !== 3'b000) begin failures++; $display("FAIL one_x_one_flags got=%b exp=000", f); end
        checks++;
        if (l !== 2) begin failures++; $display("FAIL latency got=%0d exp=2", l); end
        apply(48'h8000_0000_0000, 10'd127, 1'b1, 3'b000, r, f, l);
        checks++;
        if (r !== 32'hC0000000) begin failures++; $display("FAIL carry_norm got=%h exp=c0000000", r); end
        checks++;
        if (f !== 3'b000) begin failures++; $display("FAIL carry_norm_flags got=%b exp=000", f); end
        apply(48'h2000_0000_0000, 10'd128, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h3F800000) begin failures++; $display("FAIL left_norm got=%h exp=3f800000", r); end
    endtask

    task automatic test_round_ties;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        apply(48'h4000_0040_0000, 10'd127, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h3F800000) begin failures++; $display("FAIL tie_even got=%h exp=3f800000", r); end
        checks++;
        if (f !== 3'b001) begin failures++; $display("FAIL tie_even_flags got=%b exp=001", f); end
        apply(48'h4000_00C0_0000, 10'd127, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h3F800002) begin failures++; $display("FAIL tie_odd got=%h exp=3f800002", r); end
        checks++;
        if (f !== 3'b001) begin failures++; $display("FAIL tie_odd_flags got=%b exp=001", f); end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        apply(48'h7FFF_FFFF_FFFF, 10'd254, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h7F800000) begin failures++; $display("FAIL overflow got=%h exp=7f800000", r); end
        checks++;
        if (f !== 3'b101) begin failures++; $display("FAIL overflow_flags got=%b exp=101", f); end
    endtask

    task automatic test_denormal;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        apply(48'h4000_0000_0000, 10'd0, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h00400000) begin failures++; $display("FAIL denorm_exact got=%h exp=00400000", r); end
        checks++;
        if (f !== 3'b000) begin failures++; $display("FAIL denorm_exact_flags got=%b exp=000", f); end
        apply(48'h4000_0000_0001, 10'd0, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h00400000) begin failures++; $display("FAIL denorm_sticky got=%h exp=00400000", r); end
        checks++;
        if (f !== 3'b011) begin failures++; $display("FAIL denorm_sticky_flags got=%b exp=011", f); end
        apply(48'h7FFF_FFFF_FFFF, 10'd0, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h00800000) begin failures++; $display("FAIL denorm_to_normal got=%h exp=00800000", r); end
        checks++;
        if (f !== 3'b011) begin failures++; $display("FAIL denorm_to_normal_flags got=%b exp=011", f); end
        apply(48'h4000_0000_0000, 10'h39C, 1'b1, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h80000000) begin failures++; $display("FAIL denorm_saturate got=%h exp=80000000", r); end
        checks++;
        if (f !== 3'b011) begin failures++; $display("FAIL denorm_saturate_flags got=%b exp=011", f); end
    endtask

    task automatic test_specials;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        apply(48'h4000_0000_0000, 10'd127, 1'b1, 3'b110, r, f, l);
        checks++;
        if (r !== 32'h7FC00000 || f !== 3'b000) begin
            failures++; $display("FAIL nan got=%h/%b exp=7fc00000/000", r, f);
        end
        apply(48'h4000_0000_0000, 10'd127, 1'b1, 3'b011, r, f, l);
        checks++;
        if (r !== 32'hFF800000 || f !== 3'b000) begin
            failures++; $display("FAIL inf got=%h/%b exp=ff800000/000", r, f);
        end
        apply(48'h4000_0000_0000, 10'd127, 1'b1, 3'b001, r, f, l);
        checks++;
        if (r !== 32'h80000000 || f !== 3'b000) begin
            failures++; $display("FAIL zero got=%h/%b exp=80000000/000", r, f);
        end
        apply(48'h0, 10'd3, 1'b0, 3'b000, r, f, l);
        checks++;
        if (r !== 32'h00000000 || f !== 3'b000) begin
            failures++; $display("FAIL zero_prod got=%h/%b exp=00000000/000", r, f);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] prods [3];
        logic [31:0] exps  [3];
        int          acc, got;
        logic        rdy;
        prods[0] = 48'h4000_0000_0000; exps[0] = 32'h3F800000;
        prods[1] = 48'h8000_0000_0000; exps[1] = 32'h40000000;
        prods[2] = 48'h4000_00C0_0000; exps[2] = 32'h3F800002;
        acc = 0;
        got = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_in(prods[acc], 10'd127, 1'b0, 3'b000);
            in_valid = 1'b1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_result !== exps[0]) begin
            failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_result, exps[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 3; c++) begin
            rdy = in_ready;
            if (out_valid) begin
                checks++;
                if (out_result !== exps[got]) begin
                    failures++; $display("FAIL bp_order_%0d got=%h exp=%h", got, out_result, exps[got]);
                end
                got++;
            end
            @(posedge clk);
            if (rdy && in_valid) begin
                acc++;
                #1 in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 3) begin failures++; $display("FAIL bp_drained got=%0d exp=3", got); end
    endtask

    task automatic test_reset_midflight;
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        set_in(48'h4000_0000_0000, 10'd127, 1'b0, 3'b000);
        in_valid = 1'b1;
        @(negedge clk);
        set_in(48'h8000_0000_0000, 10'd127, 1'b0, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL mid_rst_emit got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_round_ties;
        test_overflow;
        test_denormal;
        test_specials;
        test_back_to_back;
        test_reset_midflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_mul_pack.md
# fp32_mul_pack

- Back end of the FP32 multiplier.
- Takes the 48-bit product of the two normalized 24-bit mantissas, the pre-computed result exponent and sign, and produces the packed IEEE-754 single-precision result.
- Handles post-multiply normalization, denormal right-shift, round-to-nearest-even and special-value packing.
- Two-stage pipeline with valid/ready handshake on both sides. Sits between the mantissa multiplier and the FP32 result register.

## Interface
Parameters:
- EXP_W, 10: width of signed input exponent (two's complement).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_prod  in  48  mantissa product; bit 46 weight 1.0, so product lies in [1,4) when both operands are normal.
- in_exp  in  EXP_W  signed biased exponent for a product aligned at bit 46.
- in_sign  in  1  result sign.
- in_zero / in_inf / in_nan  in  1 each  special class, decoded upstream; priority nan > inf > zero.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  packed FP32.
- out_overflow / out_underflow / out_inexact  out  1 each  IEEE flags for out_result.

## Operation
Stage 1 (align):
- If in_prod[47]=1: right-shift by 1, exp+1; the shifted-out bit joins sticky.
- Else, if in_prod[46]=0 and the product is nonzero: left-normalize to bit 46 via leading-one count, subtracting the count from exp.
- If exp ≤ 0: right-shift by 1−exp, saturated at 26 (beyond that, all bits go to sticky); exp becomes 0.
- Register: 24-bit significand, guard bit, sticky (OR of all lower bits), exp, sign, class.

Stage 2 (round and pack), RNE:
- Increment when guard & (sticky | lsb).
- Rounding carry out of bit 23 sets exp+1. A denormal rounding into bit 23 becomes exp=1.
- If exp ≥ 255 after rounding: result ±inf (0x7F800000 | sign<<31), overflow=1, inexact=1.
- Tiny result (exp=0 before rounding): pack as denormal; underflow = tiny & inexact.
- inexact = guard | sticky.
- nan → 0x7FC00000, all flags 0.
- inf → ±0x7F800000, all flags 0.
- zero or in_prod=0 → ±0, all flags 0.

## Timing
- Latency: 2 cycles from accepted input (in_valid & in_ready) to out_valid. Throughput 1/cycle when out_ready=1.
- Each stage has a valid bit. Stage 2 advances when !s2_valid | out_ready. Stage 1 advances when stage 2 can load.
- in_ready = !s1_valid | (stage 2 can load). Purely combinational from out_ready and the valid bits. No skid buffer.
- While out_valid=1 and out_ready=0: out_result and flags hold stable.
- Reset: s1_valid=s2_valid=0, out_valid=0, out_result=0, all flags 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards in-flight results; nothing is emitted.
- Simultaneous accept and emit in one cycle is legal; ordering is strictly FIFO.

## Structure
- Shared package fp32_pkg holds:
  - constants FP32_BIAS=127, FP32_EXP_MAX=8'hFF, FP32_QNAN=32'h7FC00000, FP32_INF=31'h7F800000;
  - typedef fp_class_t (ZERO, NORM, INF, NAN);
  - packed struct fp32_t {sign, exp[7:0], man[22:0]}.
- One sub-module: fp_round_rne. It takes a 24-bit significand, guard, sticky and 8-bit exponent, and returns the rounded significand, the exponent, a carry flag and inexact. It is instantiated in stage 2.

## Test plan
- 1.0×1.0: in_prod=48'h4000_0000_0000, in_exp=127, sign=0 → out_result=0x3F800000 two cycles after accept, all flags 0.
- Carry-normalize: in_prod=48'h8000_0000_0000, in_exp=127, sign=1 → 0xC0000000.
- Ties:
  - in_prod=48'h4000_0040_0000, exp=127 → 0x3F800000, inexact=1 (tie, even kept).
  - in_prod=48'h4000_00C0_0000 → 0x3F800002.
- Overflow: in_prod=48'h7FFF_FFFF_FFFF, in_exp=254 → rounds into exp 255 → 0x7F800000, overflow=1, inexact=1.
- Denormal:
  - in_prod=48'h4000_0000_0000, in_exp=0 → 0x00400000, underflow=0.
  - Same with in_prod bit 0 also set → underflow=1, inexact=1.
- Backpressure/reset:
  - out_ready=0 with 3 back-to-back inputs → exactly 2 accepted, then in_ready=0; raising out_ready returns them in order, then the third.
  - rst asserted with both stages full → out_valid=0 next cycle, nothing emitted afterward.
